// File: rtl/icache_ctrl.sv
// +----------------------------------------------------------------------------+
// | icache_ctrl: direct-mapped read-only cache controller with burst refill.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache_ctrl #(
  parameter int TAG_W = 22,
  parameter int IDX_W = 5,
  parameter int WORDS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  input  logic             flush,
  output logic [IDX_W-1:0] tag_idx,
  input  logic             tag_match,
  output logic             tag_we,
  output logic [TAG_W-1:0] tag_wtag,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rdata
);

  localparam int LINES  = 1 << IDX_W;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int PTR_W  = IDX_W + WSEL_W;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_REFILL_REQ  = 3'd2;
  localparam logic [2:0] S_REFILL_DATA = 3'd3;
  localparam logic [2:0] S_RESPOND     = 3'd4;

  localparam logic [WSEL_W-1:0] c_last_beat = WSEL_W'(WORDS - 1);

  logic [2:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [WSEL_W-1:0] r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WSEL_W-1:0] r_word;
  logic [31:0]       r_data [0:LINES*WORDS-1];

  logic             w_hit;
  logic             w_beat;
  logic             w_last_beat;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = &{1'b0, cpu_addr[1:0]};

  assign w_hit       = tag_match & r_valid[r_idx];
  assign w_beat      = (r_state == S_REFILL_DATA) & mem_valid;
  assign w_last_beat = w_beat & (r_cnt == c_last_beat);
  assign w_wr_ptr    = {r_idx, r_cnt};
  assign w_rd_ptr    = {r_idx, r_word};

  // Tag-store interface always reflects the latched access, never live cpu_addr.
  assign tag_idx   = r_idx;
  assign tag_wtag  = r_tag;
  assign tag_we    = w_last_beat;
  assign mem_req   = (r_state == S_REFILL_REQ);
  assign mem_addr  = {r_tag, r_idx, {(WSEL_W + 2){1'b0}}};
  assign cpu_ready = (r_state == S_RESPOND);
  assign cpu_rdata = (r_state == S_RESPOND) ? r_data[w_rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (cpu_req) begin
            r_tag   <= cpu_addr[31 -: TAG_W];
            r_idx   <= cpu_addr[WSEL_W + 2 +: IDX_W];
            r_word  <= cpu_addr[2 +: WSEL_W];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_state <= w_hit ? S_RESPOND : S_REFILL_REQ;
        end
        S_REFILL_REQ: begin
          if (mem_ack) begin
            r_cnt   <= '0;
            r_state <= S_REFILL_DATA;
          end
        end
        S_REFILL_DATA: begin
          if (mem_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              r_valid[r_idx] <= 1'b1;
              r_state        <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage has no reset; validity is tracked solely by r_valid.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[w_wr_ptr] <= mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_icache_ctrl: randomized scoreboard bench for icache_ctrl.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, flush, tag_match, tag_we, cpu_ready;
  logic        mem_req, mem_ack, mem_valid;
  logic [31:0] cpu_addr, cpu_rdata, mem_addr, mem_rdata;
  logic [4:0]  tag_idx;
  logic [21:0] tag_wtag;

  icache_ctrl #(.TAG_W(22), .IDX_W(5), .WORDS(8)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush),
    .tag_idx(tag_idx), .tag_match(tag_match), .tag_we(tag_we), .tag_wtag(tag_wtag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] miss_q[$];
  int checks = 0;
  int errors = 0;

  // Environment: a simple tag store, with optional forcing of the compare result.
  logic [21:0] ttag [32];
  int force_mode = 0;   // 0: real compare, 1: force match, 2: force mismatch
  assign tag_match = (force_mode == 1) ? 1'b1 :
                     (force_mode == 2) ? 1'b0 : (ttag[tag_idx] == tag_wtag);

  // Reference model: which lines hold which tag; data always equals backing memory.
  bit          mvalid [32];
  logic [21:0] mtag   [32];
  int exp_tagwe = 0;
  int tagwe_cnt = 0;

  int ack_delay  = 0;   // -1: random
  int gap_mode   = 2;   // 0: random gaps, 1: every other cycle, 2: none
  int kill_after = 8;
  int killed_cnt = 0;

  function automatic logic [31:0] memw(input logic [31:0] line, input int w);
    return ((line ^ 32'hFFFF_FC00) * 32'd3) + 32'h100 + 32'(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, cpu_ready}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_tag_we", {31'd0, tag_we}, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    clear_model();
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic do_read(input logic [31:0] addr, input int fmode, input bit fmid);
    logic [4:0]  idx = addr[9:5];
    logic [21:0] tag = addr[31:10];
    logic [31:0] line = {addr[31:5], 5'b0};
    bit tm, hit, done;
    force_mode = fmode;
    tm  = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b0 : (mtag[idx] == tag);
    hit = mvalid[idx] && tm;
    if (!hit) begin
      miss_q.push_back(line);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      exp_tagwe++;
    end
    exp_q.push_back('{memw(line, int'(addr[4:2])), hit, cyc});
    cpu_addr = addr;
    cpu_req  = 1'b1;
    @(posedge clk); #1;
    cpu_addr = $urandom;
    if (fmid) flush = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_timeout: no cpu_ready for addr %h", addr);
      finish_sim();
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    flush   = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes an access.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (tag_we) begin
        tagwe_cnt++;
        ttag[tag_idx] = tag_wtag;
      end
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: rdata %h with empty scoreboard", cpu_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", cpu_rdata, e.data);
          if (e.hit) chk("hit_latency", 32'(cyc - e.issue), 32'd2);
          else       chk("miss_latency_min", {31'd0, (cyc - e.issue) >= 11}, 32'd1);
        end
      end
    end
  end

  // Memory responder.
  initial begin
    logic [31:0] line;
    int d, b, nb;
    bit tog, gap, first;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) continue;
      line = mem_addr;
      if (miss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_req: mem_addr %h", mem_addr);
      end else begin
        chk("mem_addr", mem_addr, miss_q.pop_front());
      end
      d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 4));
      @(posedge clk); #1;
      repeat (d) begin @(posedge clk); #1; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      b = 0; tog = 1'b0; first = 1'b1; nb = kill_after;
      while (b < nb) begin
        gap = (gap_mode == 1) ? tog : (gap_mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
        tog = !tog;
        if (gap) mem_valid = 1'b0;
        else begin
          mem_valid = 1'b1;
          mem_rdata = memw(line, b);
          b++;
        end
        if (first) begin
          @(negedge clk);
          chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
          first = 1'b0;
        end
        @(posedge clk); #1;
      end
      mem_valid = 1'b0;
      if (nb < 8) begin
        killed_cnt++;
        wait (rst == 1'b1);
        wait (rst == 1'b0);
        for (int i = 0; i < 3; i++) begin
          mem_valid = 1'b1;
          mem_rdata = 32'hDEAD_0000 + 32'(i);
          @(posedge clk); #1;
        end
        mem_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin
    logic [21:0] tags [4];
    int k0;
    bit got;
    tags[0] = 22'h3FFFFF; tags[1] = 22'h000002; tags[2] = 22'h012345; tags[3] = 22'h00ABCD;
    cpu_req = 1'b0; flush = 1'b0; cpu_addr = '0;
    for (int i = 0; i < 32; i++) begin
      ttag[i] = 22'($urandom);
      mtag[i] = '0;
    end
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_tag_idx", {27'd0, tag_idx}, 32'd0);

    // First refill with forced mismatch, then forced-match hit on last word.
    ack_delay = 0; gap_mode = 2;
    do_read(32'hFFFF_FC00, 2, 1'b0);
    chk("tag_we_count", 32'(tagwe_cnt), 32'(exp_tagwe));
    do_read(32'hFFFF_FC1C, 1, 1'b0);

    // Forced match on an invalid line still misses.
    do_reset();
    do_read(32'hFFFF_FC20, 1, 1'b0);

    // Flush in IDLE, then flush held during a refill is ignored.
    do_read(32'hFFFF_FC00, 0, 1'b0);
    flush_idle();
    do_read(32'hFFFF_FC00, 1, 1'b0);
    gap_mode = 0; ack_delay = -1;
    do_read(32'h1234_5040, 0, 1'b1);
    do_read(32'hFFFF_FC00, 0, 1'b0);
    do_read(32'h1234_5044, 0, 1'b0);

    // Delayed ack with alternating gaps, then hit every word.
    ack_delay = 3; gap_mode = 1;
    do_read(32'h0000_A0E0, 0, 1'b0);
    for (int w = 0; w < 8; w++) do_read(32'h0000_A0E0 + 32'(w * 4), 0, 1'b0);
    chk("tag_we_count", 32'(tagwe_cnt), 32'(exp_tagwe));

    // Reset in the middle of a refill.
    ack_delay = 1; gap_mode = 2; kill_after = 4; force_mode = 0;
    miss_q.push_back(32'h0000_B0E0);
    k0 = killed_cnt;
    cpu_addr = 32'h0000_B0E0; cpu_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (killed_cnt != k0) got = 1'b1;
    end
    chk("kill_reached", {31'd0, got}, 32'd1);
    kill_after = 8;
    @(posedge clk); #1;
    do_reset();
    chk("tag_we_after_kill", 32'(tagwe_cnt), 32'(exp_tagwe));
    repeat (5) @(posedge clk);
    #1;
    do_read(32'h0000_B0E8, 0, 1'b0);

    // Randomized traffic over a small tag/index space.
    ack_delay = -1; gap_mode = 0;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(0, 3)], 2'b00, 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) flush_idle();
      do_read(a, 0, ($urandom_range(0, 7) == 0));
    end
    chk("tag_we_count", 32'(tagwe_cnt), 32'(exp_tagwe));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("miss_queue_empty", 32'(miss_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    finish_sim();
  end

endmodule

`default_nettype wire

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped read cache controller. Sits directly downstream of the tag store and consumes its tag-match result.
- Owns the line data array and the per-line valid bits.
- Drives the tag-store index and tag-write port. On a miss, runs a burst refill from memory.
- Geometry: 32 lines of 32 bytes. Address split is tag [31:10], index [9:5], word [4:2], byte [1:0].

Parameters:
- TAG_W, 22, tag width (addr[31:10])
- IDX_W, 5, index width; 2**IDX_W lines
- WORDS, 8, 32-bit words per line; word select is addr[4:2]

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  read request; sampled only in IDLE
- cpu_addr  in  32  byte address; captured when request accepted; addr[1:0] ignored
- cpu_rdata  out  32  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  clear all valid bits; honoured in IDLE only
- tag_idx  out  5  index presented to tag store (latched addr[9:5])
- tag_match  in  1  tag store compare result for tag_idx vs tag_wtag
- tag_we  out  1  one-cycle tag write strobe
- tag_wtag  out  22  latched addr[31:10]; used for both compare and write
- mem_req  out  1  line fetch request; held until mem_ack
- mem_addr  out  32  line address {tag, idx, 5'b0}
- mem_ack  in  1  memory accepted request
- mem_valid  in  1  refill beat valid
- mem_rdata  in  32  refill beat data, word 0 first

Behaviour:
- Reset, asynchronous:
  - state=IDLE, all valid bits=0, beat counter=0, latched addr=0.
  - cpu_ready=0, tag_we=0, mem_req=0, cpu_rdata=0.
  - Data array is not cleared.
- Reset mid-refill: refill is abandoned and no valid bit is set. A memory beat arriving after reset is ignored.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
- IDLE:
  - If flush=1, clear all valid bits; cpu_req is ignored that cycle (flush has priority).
  - Else if cpu_req=1, latch cpu_addr and go to LOOKUP.
- LOOKUP: hit = tag_match & valid[idx].
  - Hit: go to RESPOND.
  - Miss: go to REFILL_REQ.
- REFILL_REQ:
  - mem_req=1 and mem_addr={latched tag, idx, 5'b0}, both held stable.
  - On mem_ack=1: drop mem_req next cycle, counter=0, go to REFILL_DATA.
- REFILL_DATA:
  - Each cycle with mem_valid=1 writes mem_rdata into data[idx][counter], then counter+1.
  - Gaps (mem_valid=0) are allowed.
  - Beat 8 (counter=7 with mem_valid=1) additionally:
    - pulses tag_we for that cycle;
    - sets valid[idx];
    - goes to RESPOND.
- RESPOND:
  - cpu_ready=1 for exactly one cycle.
  - cpu_rdata=data[idx][latched addr[4:2]], including a word written on the final beat.
  - Next state is IDLE.
- Latency from request sampled in IDLE to cpu_ready: hit = 2 cycles; miss = 3 + (cycles until mem_ack) + (cycles to deliver 8 beats).
- Signals ignored outside their states: mem_valid outside REFILL_DATA, mem_ack outside REFILL_REQ, flush outside IDLE.
- Requester rules:
  - Hold cpu_req until cpu_ready.
  - Drop cpu_req the cycle after cpu_ready; a request still high in IDLE is a new access.
- Line replacement: a miss on a valid line overwrites it; no writeback (read-only cache).
- tag_idx/tag_wtag come from the latched address in every non-IDLE state. They do not change during an access even if cpu_addr changes.

Test Plan:
- Reset, then read 0xFFFFFC00 with tag_match=0 → mem_req with mem_addr=0xFFFFFC00; after ack, beats 0x100..0x107 → tag_we pulse on beat 8, cpu_ready with cpu_rdata=0x100.
- Read 0xFFFFFC1C after that refill, with tag_match=1 → cpu_ready 2 cycles after accept, cpu_rdata=0x107, mem_req stays 0.
- tag_match=1 but line invalid (fresh reset, idx 1) → treated as a miss; mem_addr=0xFFFFFC20.
- flush in IDLE, then re-read 0xFFFFFC00 with tag_match=1 → miss and refill; flush during REFILL_DATA has no effect.
- Refill with 3-cycle mem_ack delay and mem_valid gaps every other cycle → all 8 words are stored in order; hitting each word afterwards returns the matching data.
- Assert reset after beat 4 of a refill → IDLE, no tag_we; next read of the same line misses again.
